// File: rtl/led_driver.sv
// Four-LED output stage: per-LED static/blink/event-stretch level, gated by a global PWM duty.
// Shared timebase (us/ms ticks, blink phase, PWM counter) lives in the top; per-LED state lives in led_lane.

module led_lane #(
    parameter logic [15:0] STRETCH_LENGTH_MS = 16'd50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_ms,
    input  logic       ev,
    input  logic [1:0] mode,
    input  logic       blink_ph,
    input  logic       pwm_on,
    output logic       led
);
    typedef enum logic [1:0] {
        M_OFF     = 2'b00,
        M_ON      = 2'b01,
        M_BLINK   = 2'b10,
        M_STRETCH = 2'b11
    } mode_e;

    logic [15:0] str_cnt;
    logic        raw;

    // Event loads regardless of mode; a reload beats a same-cycle ms tick.
    always_ff @(posedge clk) begin
        if (!rst_n)
            str_cnt <= '0;
        else if (ev)
            str_cnt <= STRETCH_LENGTH_MS;
        else if (tick_ms && str_cnt != '0)
            str_cnt <= str_cnt - 16'd1;
    end

    always_comb begin
        raw = 1'b0;
        unique case (mode_e'(mode))
            M_OFF:     raw = 1'b0;
            M_ON:      raw = 1'b1;
            M_BLINK:   raw = blink_ph;
            M_STRETCH: raw = (str_cnt != '0);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            led <= 1'b0;
        else
            led <= raw & pwm_on;
    end
endmodule

module led_driver #(
    parameter int          CLK_FREQ_MHZ      = 100,
    parameter logic [15:0] STRETCH_LENGTH_MS = 16'd50,
    parameter logic [15:0] BLINK_HALF_MS     = 16'd250,
    parameter int          PWM_BITS          = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          mode_i,
    input  logic [3:0]          event_i,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic [3:0]          led_o
);
    localparam int NUM_LANES = 4;
    localparam int US_W      = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;

    logic [US_W-1:0]     us_cnt;
    logic [9:0]          ms_cnt;
    logic [15:0]         blink_cnt;
    logic                blink_ph;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick_us, tick_ms, pwm_on;

    assign tick_us = (us_cnt == US_W'(CLK_FREQ_MHZ - 1));
    assign tick_ms = tick_us && (ms_cnt == 10'd999);
    assign pwm_on  = (duty_i == '1) || (pwm_cnt < duty_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            us_cnt    <= '0;
            ms_cnt    <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            us_cnt  <= tick_us ? '0 : us_cnt + 1'b1;
            if (tick_us)
                ms_cnt <= tick_ms ? 10'd0 : ms_cnt + 10'd1;
            // One shared phase keeps every blinking LED in step.
            if (tick_ms) begin
                if (blink_cnt == BLINK_HALF_MS - 16'd1) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        led_lane #(
            .STRETCH_LENGTH_MS(STRETCH_LENGTH_MS)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick_ms  (tick_ms),
            .ev       (event_i[k]),
            .mode     (mode_i[2*k +: 2]),
            .blink_ph (blink_ph),
            .pwm_on   (pwm_on),
            .led      (led_o[k])
        );
    end
endmodule

// File: tb/tb_led_driver.sv
// Bench for led_driver: directed scenarios plus random traffic, every cycle compared
// against an arithmetic model driven by the count of edges since reset release.

module tb_led_driver;
    localparam int MS_CYC = 2000;   // 2 MHz core clock
    localparam int STR_MS = 3;
    localparam int HALF   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mode;
    logic [3:0] ev;
    logic [3:0] duty;
    logic [3:0] led;

    int total = 0;
    int bad   = 0;
    int n     = 0;            // edges since reset release
    int ev_edge [4];          // edge index at which each lane last loaded
    bit ev_vld  [4];

    led_driver #(
        .CLK_FREQ_MHZ      (2),
        .STRETCH_LENGTH_MS (16'd3),
        .BLINK_HALF_MS     (16'd2),
        .PWM_BITS          (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode_i  (mode),
        .event_i (ev),
        .duty_i  (duty),
        .led_o   (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (n=%0d)", tag, got, exp, n);
        end
    endtask

    // Expected led_o after the next edge, from the state after n edges and current inputs.
    function automatic logic [3:0] model();
        logic [3:0] r;
        bit pon, blink;
        pon   = (duty == 4'hF) || ((n % 16) < int'(duty));
        blink = ((n / (HALF * MS_CYC)) % 2) == 1;
        for (int k = 0; k < 4; k++) begin
            case (mode[2*k +: 2])
                2'b00:   r[k] = 1'b0;
                2'b01:   r[k] = 1'b1;
                2'b10:   r[k] = blink;
                default: r[k] = ev_vld[k] && ((n / MS_CYC - ev_edge[k] / MS_CYC) < STR_MS);
            endcase
        end
        return rst_n ? (r & {4{pon}}) : 4'h0;
    endfunction

    task automatic cyc(input string tag);
        logic [3:0] e;
        e = model();
        @(posedge clk);
        if (!rst_n) begin
            n = 0;
            for (int k = 0; k < 4; k++) ev_vld[k] = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (ev[k]) begin
                    ev_vld[k]  = 1'b1;
                    ev_edge[k] = n + 1;
                end
            n++;
        end
        #1;
        chk(tag, led, e);
    endtask

    task automatic run(input string tag, input int cnt);
        for (int i = 0; i < cnt; i++) cyc(tag);
    endtask

    task automatic do_reset(input int cnt);
        rst_n = 1'b0;
        run("reset", cnt);
        rst_n = 1'b1;
    endtask

    initial begin
        int hi;
        int hb [4];
        rst_n = 1'b0;
        mode  = 8'h55;
        ev    = 4'h0;
        duty  = 4'hF;
        for (int k = 0; k < 4; k++) begin ev_vld[k] = 1'b0; ev_edge[k] = 0; end

        // Reset holds LEDs dark, release lights them one cycle later
        run("reset_hold", 3);
        chk("reset_dark", led, 4'h0);
        rst_n = 1'b1;
        cyc("reset_rel");
        chk("reset_rel_on", led, 4'hF);

        // Blink from reset
        mode = 8'hAA;
        do_reset(2);
        run("blink_off", 4000);
        chk("blink_still_off", led, 4'h0);
        cyc("blink_edge");
        chk("blink_on", led, 4'hF);
        run("blink", 4500);

        // Single stretch on lane 0
        mode = 8'hFF;
        do_reset(2);
        run("str_idle", 7);
        ev = 4'b0001;
        cyc("str_load");
        ev = 4'h0;
        hi = 0;
        for (int i = 0; i < 7000; i++) begin
            cyc("stretch");
            if (led[0]) hi++;
        end
        chk("str_len_ok", (hi >= 4000 && hi <= 6001), 1);

        // Retrigger 5000 cycles after the first pulse
        do_reset(2);
        ev = 4'b0001;
        cyc("rt_load1");
        ev = 4'h0;
        run("retrig_a", 4999);
        ev = 4'b0001;
        cyc("rt_load2");
        ev = 4'h0;
        hi = 0;
        for (int i = 0; i < 7000; i++) begin
            cyc("retrig_b");
            if (led[0]) hi++;
        end
        chk("rt_len_ok", (hi >= 4000 && hi <= 6001), 1);

        // PWM duty levels
        mode = 8'h55;
        do_reset(2);
        foreach (hb[k]) hb[k] = 0;
        duty = 4'd5;
        for (int i = 0; i < 32; i++) begin
            cyc("pwm5");
            for (int k = 0; k < 4; k++) if (led[k]) hb[k]++;
        end
        for (int k = 0; k < 4; k++) chk("pwm5_count", hb[k], 10);
        duty = 4'd0;
        run("pwm0", 20);
        duty = 4'hF;
        run("pwmF", 20);

        // Mode toggled away and back during a stretch on lane 1
        mode = 8'hFF;
        do_reset(2);
        ev = 4'b0010;
        cyc("mid_load");
        ev = 4'h0;
        run("mid_a", 500);
        mode = 8'h00;
        run("mid_off", 2000);
        mode = 8'hFF;
        cyc("mid_back");
        chk("mid_resume", led[1], 1'b1);
        run("mid_b", 4500);

        // Reset in the middle of a stretch
        ev = 4'b1111;
        cyc("rs_load");
        ev = 4'h0;
        run("rs_a", 1000);
        do_reset(2);
        hi = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc("rs_after");
            if (led != 4'h0) hi++;
        end
        chk("rs_dark", hi, 0);

        // Random traffic
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 999) == 0)  mode = 8'($urandom);
            if ($urandom_range(0, 1999) == 0) duty = 4'($urandom);
            ev    = ($urandom_range(0, 299) == 0) ? 4'($urandom) : 4'h0;
            rst_n = ($urandom_range(0, 4999) != 0);
            cyc("rnd");
        end
        rst_n = 1'b1;
        ev    = 4'h0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
